mod_symbol_mapper: RTL
======================

# mod_symbol_mapper

Parametrised constellation mapper that replaces the fixed-mode mapping stage of the modulator with a runtime-selectable, handshaked block. It accepts one symbol's worth of bits per input beat, maps them to signed I/Q levels for BPSK/QPSK/QAM16/QAM64 (Gray-coded), and holds each symbol for a programmable number of samples per symbol. Its outputs feed the DDS carrier mixer; backpressure from the mixer is honoured through a valid/ready output port.

## Interface
- IQWIDTH, 16, width of signed I and Q outputs
- D, 20, unit amplitude; constellation levels are odd multiples of D
- SPSWIDTH, 8, width of the samples-per-symbol control
- clk  input  1  sole clock, all logic on rising edge
- rst  input  1  asynchronous, active-low reset
- mode  input  2  00 BPSK, 01 QPSK, 10 QAM16, 11 QAM64; sampled on input acceptance
- sps  input  SPSWIDTH  samples per symbol; 0 treated as 1; sampled on input acceptance
- dIn  input  6  symbol bits, LSB-aligned; bits above the mode's k ignored
- valIn  input  1  dIn valid
- rdyIn  output  1  block can accept a symbol this cycle
- IOut  output  IQWIDTH  signed in-phase sample
- QOut  output  IQWIDTH  signed quadrature sample
- valOut  output  1  IOut/QOut valid
- rdyOut  input  1  downstream accepts current sample
- symStart  output  1  high with valOut on the first sample of each symbol

## Operation
- Bits per symbol k: BPSK 1, QPSK 2, QAM16 4, QAM64 6.
- BPSK: b0 0→I=-D, 1→I=+D; Q=0.
- QPSK: I from b1, Q from b0; 0→-D, 1→+D.
- QAM16: I from b[3:2], Q from b[1:0]; 00→-3D, 01→-D, 11→+D, 10→+3D.
- QAM64: I from b[5:3], Q from b[2:0]; 000→-7D, 001→-5D, 011→-3D, 010→-D, 110→+D, 111→+3D, 101→+5D, 100→+7D.
- Levels computed at full precision and assigned sign-extended to IQWIDTH; elaboration fails if 7*D > 2^(IQWIDTH-1)-1.
- States: EMPTY (valOut=0) and HOLD (valOut=1, sample counter cnt, last = spsLatched-1).
- EMPTY: rdyIn=1; on valIn, latch mapped I/Q, mode, sps, cnt=0, go HOLD.
- HOLD: output fixed I/Q; each cycle with rdyOut=1 increments cnt; on cnt==last with rdyOut=1, either load next symbol (valIn=1, cnt=0, stay HOLD) or go EMPTY.
- rdyIn = (state==EMPTY) or (rdyOut and cnt==last); combinational from rdyOut, no other path.
- symStart = valOut and cnt==0.
- Changes on mode/sps while in HOLD have no effect until the next acceptance.

## Timing
- Reset (rst low): IOut=0, QOut=0, valOut=0, symStart=0, cnt=0, state EMPTY; rdyIn forced 0 while rst is low, 1 from the first cycle after release.
- Latency: symbol accepted at edge N appears on IOut/QOut with valOut=1 immediately after edge N (1 cycle).
- With rdyOut held 1 and valIn held 1: exactly sps samples per symbol, no bubbles between symbols, symStart once per symbol.
- rdyOut=0: outputs, cnt and valOut frozen; rdyIn=0 in HOLD.
- sps=1 (or 0): every handshaked output sample is a new symbol; rdyIn follows rdyOut in HOLD.
- cnt width SPSWIDTH; sps=2^SPSWIDTH-1 must hold full count without wrap.
- rst asserted mid-symbol: immediate return to reset values; partial symbol discarded, not replayed.

## Structure
- Package mod_pkg: mode enum (MOD_BPSK, MOD_QPSK, MOD_QAM16, MOD_QAM64), bits-per-symbol function, Gray level-index function.
- One sub-module mod_const_lut: combinational mode+bits → signed I/Q, parametrised by D and IQWIDTH; reusable by a future demapper reference model.
- Top holds the state register, counter, latched I/Q and handshake logic.

## Test plan
- Reset: rst low mid-HOLD with valOut=1 → IOut=QOut=0, valOut=0, rdyIn=0; after release rdyIn=1.
- BPSK, sps=4, dIn bits 1,0 back-to-back, rdyOut=1 → I = +20×4 then -20×4, Q=0, symStart at samples 0 and 4, no gaps.
- QAM64, sps=1, sweep dIn 0..63 → every I/Q matches Gray table (e.g. 6'b100_000 → I=+140, Q=-140); rdyIn constant 1.
- QAM16, sps=3, rdyOut toggled 1,0,1,0 → each sample held while rdyOut=0, exactly 3 accepted samples per symbol, rdyIn high only in the last-sample cycle with rdyOut=1.
- Mode/sps changed from QPSK/sps=2 to QAM16/sps=5 during HOLD → current symbol finishes with 2 samples at ±20, next symbol uses 5 samples at QAM16 levels.
- sps=0, QPSK dIn=2'b10 → single sample I=+20, Q=-20, symStart=1.

Source files
------------

// File: rtl/mod_symbol_mapper_pkg.sv
// Shared constellation definitions for the symbol mapper and future demapper models.
package mod_pkg;

    typedef enum logic [1:0] {
        MOD_BPSK  = 2'b00,
        MOD_QPSK  = 2'b01,
        MOD_QAM16 = 2'b10,
        MOD_QAM64 = 2'b11
    } mod_mode_e;

    typedef enum logic {
        ST_EMPTY,
        ST_HOLD
    } map_state_e;

    function automatic int unsigned bits_per_symbol(input mod_mode_e m);
        case (m)
            MOD_BPSK:  return 1;
            MOD_QPSK:  return 2;
            MOD_QAM16: return 4;
            default:   return 6;
        endcase
    endfunction

    // Gray code -> binary position, then centred to an odd multiplier (-(2^n-1) .. +(2^n-1)).
    function automatic int gray_level_idx(input logic [2:0] g, input int unsigned nbits);
        logic [2:0] b;
        b[2] = g[2];
        b[1] = g[2] ^ g[1];
        b[0] = b[1] ^ g[0];
        return 2 * int'(b) - ((1 << nbits) - 1);
    endfunction

endpackage

// File: rtl/mod_symbol_mapper_lut.sv
// Combinational constellation lookup: mode + symbol bits -> signed I/Q levels.
module mod_const_lut
    import mod_pkg::*;
#(
    parameter int IQWIDTH = 16,
    parameter int D       = 20
) (
    input  logic [1:0]         mode,
    input  logic [5:0]         bits,
    output logic [IQWIDTH-1:0] i_lvl,
    output logic [IQWIDTH-1:0] q_lvl
);

    if (7 * D > (2 ** (IQWIDTH - 1)) - 1) begin : g_range_check
        $error("mod_const_lut: 7*D does not fit in IQWIDTH signed bits");
    end

    mod_mode_e   m;
    int unsigned axis_bits;
    int          i_mult;
    int          q_mult;

    assign m = mod_mode_e'(mode);

    always_comb begin
        axis_bits = bits_per_symbol(m) >> 1;
        i_mult    = 0;
        q_mult    = 0;
        case (m)
            MOD_BPSK: begin
                i_mult = gray_level_idx({2'b00, bits[0]}, 1);
            end
            MOD_QPSK: begin
                i_mult = gray_level_idx({2'b00, bits[1]}, axis_bits);
                q_mult = gray_level_idx({2'b00, bits[0]}, axis_bits);
            end
            MOD_QAM16: begin
                i_mult = gray_level_idx({1'b0, bits[3:2]}, axis_bits);
                q_mult = gray_level_idx({1'b0, bits[1:0]}, axis_bits);
            end
            MOD_QAM64: begin
                i_mult = gray_level_idx(bits[5:3], axis_bits);
                q_mult = gray_level_idx(bits[2:0], axis_bits);
            end
            default: begin
                i_mult = 0;
                q_mult = 0;
            end
        endcase
        i_lvl = IQWIDTH'(i_mult * D);
        q_lvl = IQWIDTH'(q_mult * D);
    end

endmodule

// File: rtl/mod_symbol_mapper.sv
// Handshaked constellation mapper: latches one mapped symbol and repeats it for sps samples.
module mod_symbol_mapper
    import mod_pkg::*;
#(
    parameter int IQWIDTH  = 16,
    parameter int D        = 20,
    parameter int SPSWIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          mode,
    input  logic [SPSWIDTH-1:0] sps,
    input  logic [5:0]          dIn,
    input  logic                valIn,
    output logic                rdyIn,
    output logic [IQWIDTH-1:0]  IOut,
    output logic [IQWIDTH-1:0]  QOut,
    output logic                valOut,
    input  logic                rdyOut,
    output logic                symStart
);

    map_state_e          state_q, state_d;
    logic [SPSWIDTH-1:0] cnt_q, cnt_d;
    logic [SPSWIDTH-1:0] last_q, last_d;
    logic [IQWIDTH-1:0]  i_q, i_d;
    logic [IQWIDTH-1:0]  q_q, q_d;
    logic [IQWIDTH-1:0]  lut_i, lut_q;
    logic                cnt_last;
    logic                load;

    mod_const_lut #(
        .IQWIDTH (IQWIDTH),
        .D       (D)
    ) u_lut (
        .mode  (mode),
        .bits  (dIn),
        .i_lvl (lut_i),
        .q_lvl (lut_q)
    );

    always_comb begin
        cnt_last = (cnt_q == last_q);
        rdyIn    = rst & ((state_q == ST_EMPTY) | (rdyOut & cnt_last));
        load     = valIn & rdyIn;

        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        i_d     = i_q;
        q_d     = q_q;

        if (state_q == ST_HOLD && rdyOut) begin
            if (cnt_last) begin
                state_d = ST_EMPTY;
                cnt_d   = '0;
                i_d     = '0;
                q_d     = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // A new symbol overrides the end-of-symbol drain, giving bubble-free back-to-back output.
        if (load) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
            last_d  = (sps == '0) ? '0 : sps - 1'b1;
            i_d     = lut_i;
            q_d     = lut_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_EMPTY;
            cnt_q   <= '0;
            last_q  <= '0;
            i_q     <= '0;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            i_q     <= i_d;
            q_q     <= q_d;
        end
    end

    assign valOut   = (state_q == ST_HOLD);
    assign symStart = valOut & (cnt_q == '0);
    assign IOut     = i_q;
    assign QOut     = q_q;

endmodule
